booth_seq_multiplier: RTL and testbench

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

---
 rtl/booth_pkg.sv | 12 +
 rtl/booth_step.sv | 37 +++
 rtl/booth_seq_multiplier.sv | 101 ++++++++++
 tb/tb_booth_seq_multiplier.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and default operand width for the Booth multiplier
package booth_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth iteration: add/sub M by {Q[0],Q_1}, then arithmetic shift right
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    // One guard bit keeps Acc-M exact when M is the most negative value.
    logic [WIDTH:0] acc_ext;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    assign acc_ext = {acc[WIDTH-1], acc};
    assign m_ext   = {m[WIDTH-1], m};

    // Booth recoding of the current multiplier bit pair selects add, subtract or hold.
    always_comb begin
        sum = acc_ext;
        case ({q[0], q_1})
            2'b01:   sum = acc_ext + m_ext;
            2'b10:   sum = acc_ext - m_ext;
            default: sum = acc_ext;
        endcase
    end

    // Shifting the widened sum right drops its LSB into Q; the guard bit becomes the new sign.
    assign acc_next = sum[WIDTH:1];
    assign q_next   = {sum[0], q[WIDTH-1:1]};
    assign q_1_next = q[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-2 Booth signed multiplier (optional macro BOOTH_ZERO_SKIP_EN)
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

    booth_state_t   state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] q_step;
    logic             q_1_step;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .acc_next (acc_step),
        .q_next   (q_step),
        .q_1_next (q_1_step)
    );

    // Control FSM with registered outputs; done/P are written on the DONE->IDLE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            P     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= A;
                        q     <= B;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        count <= COUNT_INIT;
                        busy  <= 1'b1;
`ifdef BOOTH_ZERO_SKIP_EN
                        // A zero operand makes the product zero; clearing Q lets DONE publish 0 directly.
                        if (A == '0 || B == '0) begin
                            q     <= '0;
                            count <= '0;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    q     <= q_step;
                    q_1   <= q_1_step;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    P     <= {acc, q};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - directed table-driven bench for booth_seq_multiplier at WIDTH=8
module tb_booth_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        busy;
    logic        done;

    int checks;
    int errors;

`ifdef BOOTH_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 9;
`endif

    booth_seq_multiplier #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one start pulse, then count edges until done and cycles with busy high.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           output int edges, output int busy_cnt, output logic timed_out);
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        @(negedge clk);
        edges = 0;
        busy_cnt = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    int   edges;
    int   busy_cnt;
    logic tmo;
    int   cyc;
    int   pulse_cyc[2];
    logic [15:0] pulse_p[2];
    int   npulse;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        A      = '0;
        B      = '0;

        vecs[0] = '{8'd3,   8'd5,   16'd15,    9};
        vecs[1] = '{8'hF9,  8'd6,   16'hFFD6,  9};
        vecs[2] = '{8'h80,  8'h80,  16'h4000,  9};
        vecs[3] = '{8'h80,  8'd127, 16'hC080,  9};
        vecs[4] = '{8'd127, 8'd127, 16'h3F01,  9};
        vecs[5] = '{8'hFF,  8'd1,   16'hFFFF,  9};
        vecs[6] = '{8'd1,   8'h80,  16'hFF80,  9};
        vecs[7] = '{8'hF9,  8'hFA,  16'd42,    9};
        vecs[8] = '{8'd0,   8'd77,  16'd0,     ZLAT};
        vecs[9] = '{8'd5,   8'hFD,  16'hFFF1,  9};

        repeat (3) @(negedge clk);
        check("reset_P", 32'(P), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_mul(vecs[i].a, vecs[i].b, edges, busy_cnt, tmo);
            check($sformatf("v%0d_timeout", i), 32'(tmo), 32'h0);
            check($sformatf("v%0d_P", i), 32'(P), 32'(vecs[i].p));
            check($sformatf("v%0d_latency", i), 32'(edges), 32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'(vecs[i].lat));
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'h0);
            check($sformatf("v%0d_P_hold", i), 32'(P), 32'(vecs[i].p));
        end

        // Reset four cycles into RUN clears P and busy without waiting for a clock edge.
        @(negedge clk);
        start = 1'b1;
        A = 8'd5;
        B = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_P", 32'(P), 32'h0);
        check("midrun_rst_busy", 32'(busy), 32'h0);
        check("midrun_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_mul(8'd2, 8'd2, edges, busy_cnt, tmo);
        check("after_rst_timeout", 32'(tmo), 32'h0);
        check("after_rst_P", 32'(P), 32'd4);
        check("after_rst_latency", 32'(edges), 32'd9);

        // A start pulse while busy must neither disturb the running multiply nor queue another.
        @(negedge clk);
        start = 1'b1;
        A = 8'd3;
        B = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        A = 8'd2;
        B = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                tmo = 1'b0;
                break;
            end
        end
        check("ignore_timeout", 32'(tmo), 32'h0);
        check("ignore_P", 32'(P), 32'd15);
        repeat (2) @(negedge clk);
        check("ignore_no_queue_busy", 32'(busy), 32'h0);

        // start held high gives back-to-back multiplies; operands change after the first sample.
        @(negedge clk);
        start = 1'b1;
        A = 8'd1;
        B = 8'd1;
        @(posedge clk);
        #1;
        A = 8'hFF;
        B = 8'hFF;
        npulse = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                pulse_cyc[npulse] = cyc;
                pulse_p[npulse] = P;
                npulse++;
                if (npulse == 2) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        check("b2b_pulse_count", 32'(npulse), 32'd2);
        if (npulse == 2) begin
            check("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd10);
            check("b2b_P0", 32'(pulse_p[0]), 32'd1);
            check("b2b_P1", 32'(pulse_p[1]), 32'd1);
        end
        repeat (3) @(negedge clk);
        check("b2b_idle_after", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
